ofm_max_pool: RTL and testbench
===============================

// Module: ofm_max_pool
// PURPOSE
//  Streaming 2x2/stride-2 max-pool stage directly downstream of the layer-2 PE outputs.
//  Consumes one 8-bit OFM pixel per accepted beat in row-major order and keeps one pooled row in a line buffer.
//  Emits one pooled pixel, plus its linear write address, per 2x2 window to the next OFM memory.
//  Handles one feature map (one kernel channel) per start; one instance per kernel.
// PARAMETERS
//  IMG_W   12  input map width in pixels; must be even and >= 2 (elaboration $error otherwise)
//  IMG_H   12  input map height in pixels; must be even and >= 2 (elaboration $error otherwise)
//  DATA_W  8   pixel width, two's-complement signed
// PORTS
//  clk        in   1                                  clock, rising edge
//  rst        in   1                                  asynchronous, active-high reset
//  start      in   1                                  begin a new map; sampled in IDLE only
//  in_valid   in   1                                  in_data holds the next pixel this cycle
//  in_data    in   DATA_W                             input pixel, signed
//  out_valid  out  1                                  out_data/out_addr valid, one-cycle strobe
//  out_data   out  DATA_W                             pooled pixel
//  out_addr   out  $clog2((IMG_W/2)*(IMG_H/2))        linear address of the pooled pixel
//  busy       out  1                                  high while in RUN
//  done       out  1                                  one-cycle pulse after the last pooled pixel
// BEHAVIOUR
//  Reset: state=IDLE; counters, pair register and out_addr = 0; out_valid/out_data/busy/done = 0.
//   Line buffer contents are don't-care after reset.
//  FSM: IDLE -start-> RUN; RUN -last pixel accepted-> DONE; DONE -> IDLE (unconditional, 1 cycle).
//  Pixels are accepted only in RUN when in_valid=1. in_valid in IDLE or DONE is ignored.
//   start in RUN or DONE is ignored. in_valid may drop for any number of cycles; counters hold.
//  Counters: col 0..IMG_W-1 and row 0..IMG_H-1; col wraps to 0 and row increments on col=IMG_W-1.
//  Let p = in_data after the pre-stage; with POOL_RELU_EN, negative values are clamped to 0.
//  Even col: pair_reg <= p.
//  Odd col: m = smax(pair_reg, p), where smax is a signed comparison and ties return either operand.
//   Even row: lbuf[col>>1] <= m.
//   Odd row: out_data <= smax(lbuf[col>>1], m); out_valid <= 1 on the next edge (latency 1 cycle).
//    out_addr = output count before the increment, then the count increments.
//  Output count wraps to 0 at each start. Addresses run 0..(IMG_W/2)*(IMG_H/2)-1 with no gaps.
//  On the accept of pixel (row=IMG_H-1, col=IMG_W-1), the FSM moves to DONE.
//   The last out_valid and done are asserted in the same cycle. busy drops that cycle.
//  No backpressure: the consumer must take out_valid beats unconditionally.
//  rst mid-map: immediate return to IDLE, all outputs 0. A partial map is discarded; no done.
//  Line-buffer read and write happen on different rows, so there is no hazard inside a row.
// CONFIGURATION
//  POOL_RELU_EN defined: ReLU is applied before pooling; out_data is never negative.
//  POOL_RELU_EN undefined: raw signed max-pool; negative outputs pass through.
//   The datapath is otherwise identical.
// TESTING
//  T1: IMG_W=IMG_H=4; start, then pixels 0..15 back-to-back
//      -> out_valid x4 with (addr,data) = (0,5), (1,7), (2,13), (3,15); done with the 4th strobe.
//  T2: same map with in_valid toggled 1-0-1-0
//      -> identical outputs; each strobe comes 1 cycle after the odd-row/odd-col accept.
//  T3: all 16 pixels = 8'hFD (-3)
//      -> with POOL_RELU_EN: four outputs of 8'h00; without it: four outputs of 8'hFD.
//  T4: window {-128,127,0,-1} at position 0
//      -> out_data=127 in both builds. A window of all -128 gives 0 (RELU) or 8'h80.
//  T5: assert rst after 9 pixels, then start and a full map
//      -> no done during the aborted map; the fresh map gives the T1 results from addr 0.
//  T6: start pulsed mid-RUN and in_valid driven in IDLE
//      -> both ignored; output count and addresses unchanged. busy=1 only from start+1 to the last accept.

Source files
------------

// File: rtl/ofm_max_pool.sv
// ofm_max_pool: streaming 2x2 / stride-2 max-pool with a one-pooled-row line buffer.
// Optional macro POOL_RELU_EN: clamp negative pixels to zero before pooling.
module ofm_max_pool #(
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 12,
  parameter int DATA_W = 8,
  localparam int OUT_N  = (IMG_W / 2) * (IMG_H / 2),
  localparam int ADDR_W = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_N  = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

  if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
    $error("ofm_max_pool: IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
    $error("ofm_max_pool: IMG_H must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DATA_W-1:0]   pair_q, pair_d;
  logic [ADDR_W-1:0]   out_cnt_q, out_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;

  logic [DATA_W-1:0]   lbuf [LB_N];
  logic [DATA_W-1:0]   lb_rd_q;
  logic [LB_AW-1:0]    lb_idx;
  logic                lb_we;
  logic                lb_re;

  logic [DATA_W-1:0]   pix_p;
  logic [DATA_W-1:0]   win_max;
  logic                col_last;
  logic                row_last;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  // Pre-stage: optional ReLU ahead of the comparators.
  always_comb begin
`ifdef POOL_RELU_EN
    pix_p = in_data[DATA_W-1] ? '0 : in_data;
`else
    pix_p = in_data;
`endif
  end

  assign win_max  = smax(pair_q, pix_p);
  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  assign lb_idx   = LB_AW'(col_q >> 1);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    lb_we       = 1'b0;
    lb_re       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          col_d     = '0;
          row_d     = '0;
          pair_d    = '0;
          out_cnt_d = '0;
        end
      end

      S_RUN: begin
        if (in_valid) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end

          if (!col_q[0]) begin
            pair_d = pix_p;
            // Fetch the upper-row partial max now so it is registered by the odd column.
            lb_re  = row_q[0];
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = smax(lb_rd_q, win_max);
            out_addr_d  = out_cnt_q;
            out_cnt_d   = out_cnt_q + 1'b1;
          end

          if (col_last && row_last) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Line buffer: plain array with registered read so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lbuf[lb_idx] <= win_max;
    end
    if (lb_re) begin
      lb_rd_q <= lbuf[lb_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ofm_max_pool.sv
// tb_ofm_max_pool: scenario tasks for ofm_max_pool on a 4x4 map, checked against a
// window-maximum reference model computed directly from the pixel array.
module tb_ofm_max_pool;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int NO = (W / 2) * (H / 2);
  localparam int AW = $clog2(NO);
  localparam int NP = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;

  ofm_max_pool #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] pix [NP];
  int exp_data[$];
  int exp_cyc[$];
  int obs_data[$];
  int obs_addr[$];
  int obs_done[$];
  int obs_cyc[$];
  int done_cnt = 0;
  bit busy_at_start, busy_at_last, done_at_last;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      obs_data.push_back(int'(out_data));
      obs_addr.push_back(int'(out_addr));
      obs_done.push_back(int'(done));
      obs_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  function automatic int pix_val(input logic [DW-1:0] v);
    int s;
    s = int'($signed(v));
`ifdef POOL_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Reference: maximum of each 2x2 window in row-major window order.
  task automatic build_model();
    exp_data.delete();
    for (int wr = 0; wr < H / 2; wr++) begin
      for (int wc = 0; wc < W / 2; wc++) begin
        int m;
        m = -100000;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (pix_val(pix[(2 * wr + dr) * W + 2 * wc + dc]) > m)
              m = pix_val(pix[(2 * wr + dr) * W + 2 * wc + dc]);
        exp_data.push_back(m & 255);
      end
    end
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_addr.delete(); obs_done.delete(); obs_cyc.delete();
    exp_cyc.delete();
  endtask

  // gap_mode: 0 back-to-back, 1 one idle between beats, 2 random idles.
  task automatic run_map(input int gap_mode, input bit mid_start, input bit done_start);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    busy_at_start = busy;
    for (int i = 0; i < NP; i++) begin
      int idle;
      idle = (gap_mode == 1) ? ((i > 0) ? 1 : 0) :
             (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (idle) begin
        in_valid = 1'b0; in_data = DW'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = pix[i]; start = (mid_start && i == 5);
      @(posedge clk); #1;
      start = 1'b0;
      if (((i / W) % 2 == 1) && ((i % W) % 2 == 1)) exp_cyc.push_back(cyc);
    end
    in_valid = 1'b0; in_data = DW'($urandom);
    busy_at_last = busy;
    done_at_last = done;
    if (done_start) begin
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("FAIL reset out_data: got %h want 00", out_data); end
    if (out_addr !== '0) begin n_fail++; $display("FAIL reset out_addr: got %0d want 0", out_addr); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle busy: got %b want 0", busy); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle out_valid: got %b want 0", out_valid); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    for (int pat = 0; pat < 5; pat++) begin
      int d0;
      int gap;
      for (int i = 0; i < NP; i++) begin
        case (pat)
          0, 1:    pix[i] = DW'(i);
          2:       pix[i] = 8'hFD;
          3:       pix[i] = DW'($urandom);
          default: pix[i] = 8'h80;
        endcase
      end
      if (pat == 3) begin
        pix[0] = 8'h80; pix[1] = 8'h7F; pix[4] = 8'h00; pix[5] = 8'hFF;
      end
      gap = (pat == 1) ? 1 : 0;
      clear_obs(); build_model(); d0 = done_cnt;
      run_map(gap, 1'b0, 1'b0);
      n_checks++;
      if (obs_data.size() != NO) begin
        n_fail++; $display("FAIL stream pat%0d beats: got %0d want %0d", pat, obs_data.size(), NO);
      end
      for (int k = 0; k < obs_data.size() && k < NO; k++) begin
        n_checks += 4;
        if (obs_addr[k] != k) begin n_fail++; $display("FAIL stream pat%0d beat%0d addr: got %0d want %0d", pat, k, obs_addr[k], k); end
        if (obs_data[k] != exp_data[k]) begin n_fail++; $display("FAIL stream pat%0d beat%0d data: got %02h want %02h", pat, k, obs_data[k], exp_data[k]); end
        if (obs_done[k] != ((k == NO - 1) ? 1 : 0)) begin n_fail++; $display("FAIL stream pat%0d beat%0d done: got %0d want %0d", pat, k, obs_done[k], (k == NO - 1) ? 1 : 0); end
        if (obs_cyc[k] != exp_cyc[k]) begin n_fail++; $display("FAIL stream pat%0d beat%0d latency: got cycle %0d want %0d", pat, k, obs_cyc[k], exp_cyc[k]); end
      end
      n_checks++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL stream pat%0d done pulses: got %0d want 1", pat, done_cnt - d0); end
      $display("test_stream pattern %0d: %0d beats", pat, obs_data.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    for (int i = 0; i < NP; i++) pix[i] = DW'(i);
    clear_obs(); d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = pix[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort busy before rst: got %b want 1", busy); end
    if (obs_data.size() != 2) begin n_fail++; $display("FAIL abort partial beats: got %0d want 2", obs_data.size()); end
    rst = 1'b1; #1;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort out_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("FAIL abort out_data: got %h want 00", out_data); end
    if (out_addr !== '0) begin n_fail++; $display("FAIL abort out_addr: got %0d want 0", out_addr); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL abort done: got %b want 0", done); end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL abort done pulses: got %0d want 0", done_cnt - d0); end
    clear_obs(); build_model();
    run_map(0, 1'b0, 1'b0);
    n_checks += 2;
    if (obs_data.size() != NO) begin n_fail++; $display("FAIL rerun beats: got %0d want %0d", obs_data.size(), NO); end
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL rerun done pulses: got %0d want 1", done_cnt - d0); end
    for (int k = 0; k < obs_data.size() && k < NO; k++) begin
      n_checks += 2;
      if (obs_addr[k] != k) begin n_fail++; $display("FAIL rerun beat%0d addr: got %0d want %0d", k, obs_addr[k], k); end
      if (obs_data[k] != exp_data[k]) begin n_fail++; $display("FAIL rerun beat%0d data: got %02h want %02h", k, obs_data[k], exp_data[k]); end
    end
    $display("test_reset_mid: rerun %0d beats", obs_data.size());
  endtask

  task automatic test_start_ignored();
    int d0;
    clear_obs();
    repeat (4) begin
      in_valid = 1'b1; in_data = DW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 2;
    if (obs_data.size() != 0) begin n_fail++; $display("FAIL idle in_valid beats: got %0d want 0", obs_data.size()); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle in_valid busy: got %b want 0", busy); end
    for (int i = 0; i < NP; i++) pix[i] = DW'($urandom);
    clear_obs(); build_model(); d0 = done_cnt;
    run_map(0, 1'b1, 1'b1);
    n_checks += 6;
    if (busy_at_start !== 1'b1) begin n_fail++; $display("FAIL busy after start: got %b want 1", busy_at_start); end
    if (busy_at_last !== 1'b0) begin n_fail++; $display("FAIL busy after last accept: got %b want 0", busy_at_last); end
    if (done_at_last !== 1'b1) begin n_fail++; $display("FAIL done after last accept: got %b want 1", done_at_last); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy after start in DONE: got %b want 0", busy); end
    if (obs_data.size() != NO) begin n_fail++; $display("FAIL start_ignored beats: got %0d want %0d", obs_data.size(), NO); end
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL start_ignored done pulses: got %0d want 1", done_cnt - d0); end
    for (int k = 0; k < obs_data.size() && k < NO; k++) begin
      n_checks += 2;
      if (obs_addr[k] != k) begin n_fail++; $display("FAIL start_ignored beat%0d addr: got %0d want %0d", k, obs_addr[k], k); end
      if (obs_data[k] != exp_data[k]) begin n_fail++; $display("FAIL start_ignored beat%0d data: got %02h want %02h", k, obs_data[k], exp_data[k]); end
    end
    $display("test_start_ignored: %0d beats", obs_data.size());
  endtask

  task automatic test_random();
    for (int m = 0; m < 6; m++) begin
      int d0;
      for (int i = 0; i < NP; i++) pix[i] = DW'($urandom);
      clear_obs(); build_model(); d0 = done_cnt;
      run_map(2, 1'b0, 1'b0);
      n_checks += 2;
      if (obs_data.size() != NO) begin n_fail++; $display("FAIL random map%0d beats: got %0d want %0d", m, obs_data.size(), NO); end
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL random map%0d done pulses: got %0d want 1", m, done_cnt - d0); end
      for (int k = 0; k < obs_data.size() && k < NO; k++) begin
        n_checks += 3;
        if (obs_addr[k] != k) begin n_fail++; $display("FAIL random map%0d beat%0d addr: got %0d want %0d", m, k, obs_addr[k], k); end
        if (obs_data[k] != exp_data[k]) begin n_fail++; $display("FAIL random map%0d beat%0d data: got %02h want %02h", m, k, obs_data[k], exp_data[k]); end
        if (obs_cyc[k] != exp_cyc[k]) begin n_fail++; $display("FAIL random map%0d beat%0d latency: got cycle %0d want %0d", m, k, obs_cyc[k], exp_cyc[k]); end
      end
      $display("test_random map %0d: %0d beats", m, obs_data.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_stream();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
